reg_dst_pipeline: RTL
=====================

// Module: reg_dst_pipeline
// PURPOSE
//  Parametrised successor to the rt/rd destination mux. Selects the write-register
//  index (rt, rd or link register) for the instruction leaving ID, then tracks it
//  with a valid bit through STAGES pipeline stages (EX, MEM, WB by default).
//  Emits the WB write target and per-stage match flags for hazard/forwarding units.
// PARAMETERS
//  BITS_REGS  5   width of a register index
//  STAGES     3   tracked stages; index 0 = EX, STAGES-1 = WB (min 2)
//  LINK_REG   31  register written by link instructions (JAL/JALR)
// PORTS
//  i_clk          in   1                  clock, rising edge
//  i_reset        in   1                  synchronous reset, active-high
//  i_reg_dst_sel  in   2                  00 rt, 01 rd, 10 LINK_REG, 11 no write
//  i_reg_write    in   1                  ID instruction writes the register file
//  i_rt           in   BITS_REGS          rt field of ID instruction
//  i_rd           in   BITS_REGS          rd field of ID instruction
//  i_stall        in   1                  ID stalled: bubble into stage 0
//  i_flush        in   1                  ID flushed: bubble into stage 0
//  i_rs_query     in   BITS_REGS          source index compared for hazards
//  i_rt_query     in   BITS_REGS          second source index compared
//  o_dst_stage    out  STAGES*BITS_REGS   packed dst index per stage, stage k at [k*BITS_REGS +: BITS_REGS]
//  o_valid_stage  out  STAGES             valid (will write) per stage
//  o_wb_reg       out  BITS_REGS          dst of stage STAGES-1
//  o_wb_write     out  1                  valid of stage STAGES-1
//  o_match_rs     out  STAGES             per-stage match against i_rs_query
//  o_match_rt     out  STAGES             per-stage match against i_rt_query
// BEHAVIOUR
//  - Reset: all dst entries 0, all valid 0; all outputs therefore 0 on the cycle after reset.
//  - Selection (combinational): sel 00->i_rt, 01->i_rd, 10->LINK_REG, 11->index 0.
//  - Capture valid = i_reg_write & (sel!=11) & (selected index != 0); $zero writes never tracked.
//  - Each rising edge (no reset): stage k <= stage k-1 for k>=1; stage 0 <= selected
//    index and capture valid. Latency ID->WB output = STAGES cycles.
//  - i_stall or i_flush: stage 0 loads dst 0, valid 0; stages 1..STAGES-1 still
//    advance. Stall and flush together: same bubble. The ID instruction is
//    re-presented by the upstream stage; this block does not hold it.
//  - o_match_xx[k] = o_valid_stage[k] & (dst[k]==query) & (query!=0); purely combinational, no latency.
//  - Multiple stages may match at once; all matching bits assert.
//  - Reset mid-operation wins over stall/flush/advance; in-flight entries discarded.
//  - LINK_REG beyond 2**BITS_REGS-1 is a configuration error (elaboration check).
// CONFIGURATION
//  REG_DST_FWD_PRIORITY_EN defined: adds outputs o_fwd_rs and o_fwd_rt, each
//   $clog2(STAGES+1) bits: 0 = no match, else 1 + index of lowest-numbered
//   (youngest) matching stage. Combinational, same timing as o_match_xx.
//  Not defined: those ports and the priority logic do not exist; all other behaviour identical.
// TESTING
//  1 Reset: i_reset=1 two cycles, random inputs -> all outputs 0 on release.
//  2 Latency: sel=01, rd=7, write=1 one cycle then sel=11 -> o_wb_reg=7, o_wb_write=1
//    exactly 3 cycles later, for one cycle only; valid walks stage 0,1,2.
//  3 Select/zero: sel=00 rt=0 write=1 -> valid_stage[0]=0; sel=10 -> dst[0]=31 valid 1;
//    sel=11 write=1 -> valid 0.
//  4 Stall: dst 5 in stage 0, next cycle i_stall=1 with rd=9 -> stage1=5 valid,
//    stage0 valid 0; 9 enters only when stall drops.
//  5 Matches: stages hold {10,10,3} valid -> i_rs_query=10 gives o_match_rs=3'b011;
//    query 0 -> 3'b000; with REG_DST_FWD_PRIORITY_EN, o_fwd_rs=1.
//  6 Reset mid-flight: three valid entries, assert i_reset one cycle with i_stall=1
//    -> all valid 0 next cycle, o_wb_write never pulses for flushed entries.

Source files
------------

// File: rtl/reg_dst_pipeline.sv
// Destination-register tracker: picks rt/rd/link for the ID instruction and carries it with a
// valid bit through STAGES stages. Optional macro REG_DST_FWD_PRIORITY_EN adds forwarding priority outputs.
module reg_dst_pipeline #(
    parameter int BITS_REGS = 5,
    parameter int STAGES    = 3,
    parameter int LINK_REG  = 31,
    localparam int FW       = $clog2(STAGES + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [1:0]                    i_reg_dst_sel,
    input  logic                          i_reg_write,
    input  logic [BITS_REGS-1:0]          i_rt,
    input  logic [BITS_REGS-1:0]          i_rd,
    input  logic                          i_stall,
    input  logic                          i_flush,
    input  logic [BITS_REGS-1:0]          i_rs_query,
    input  logic [BITS_REGS-1:0]          i_rt_query,
    output logic [STAGES*BITS_REGS-1:0]   o_dst_stage,
    output logic [STAGES-1:0]             o_valid_stage,
    output logic [BITS_REGS-1:0]          o_wb_reg,
    output logic                          o_wb_write,
    output logic [STAGES-1:0]             o_match_rs,
    output logic [STAGES-1:0]             o_match_rt
`ifdef REG_DST_FWD_PRIORITY_EN
    ,
    output logic [FW-1:0]                 o_fwd_rs,
    output logic [FW-1:0]                 o_fwd_rt
`endif
);

    localparam logic [BITS_REGS-1:0] ZERO_IDX = {BITS_REGS{1'b0}};

    if (LINK_REG > (2 ** BITS_REGS) - 1) begin : g_link_reg_check
        $error("reg_dst_pipeline: LINK_REG does not fit in BITS_REGS bits");
    end
    if (STAGES < 2) begin : g_stages_check
        $error("reg_dst_pipeline: STAGES must be at least 2");
    end

    logic [BITS_REGS-1:0] sel_idx_s;
    logic                 cap_valid_s;
    logic [BITS_REGS-1:0] stage0_dst_s;
    logic                 stage0_valid_s;
    logic [BITS_REGS-1:0] dst_r [0:STAGES-1];
    logic [STAGES-1:0]    valid_r;
    logic [STAGES-1:0]    match_rs_s;
    logic [STAGES-1:0]    match_rt_s;

    // Destination select and capture qualification; a stall or flush turns stage 0 into a bubble.
    always_comb begin
        sel_idx_s = ZERO_IDX;
        case (i_reg_dst_sel)
            2'b00:   sel_idx_s = i_rt;
            2'b01:   sel_idx_s = i_rd;
            2'b10:   sel_idx_s = BITS_REGS'(LINK_REG);
            default: sel_idx_s = ZERO_IDX;
        endcase
        cap_valid_s = i_reg_write & (i_reg_dst_sel != 2'b11) & (sel_idx_s != ZERO_IDX);
        if (i_stall || i_flush) begin
            stage0_dst_s   = ZERO_IDX;
            stage0_valid_s = 1'b0;
        end else begin
            stage0_dst_s   = sel_idx_s;
            stage0_valid_s = cap_valid_s;
        end
    end

    // Pipeline shift register; reset discards everything in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < STAGES; k++) begin
                dst_r[k] <= ZERO_IDX;
            end
            valid_r <= {STAGES{1'b0}};
        end else begin
            dst_r[0] <= stage0_dst_s;
            for (int k = 1; k < STAGES; k++) begin
                dst_r[k] <= dst_r[k-1];
            end
            valid_r <= {valid_r[STAGES-2:0], stage0_valid_s};
        end
    end

    // Hazard compare per stage; a zero query never matches.
    always_comb begin
        match_rs_s = {STAGES{1'b0}};
        match_rt_s = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            match_rs_s[k] = valid_r[k] & (dst_r[k] == i_rs_query) & (i_rs_query != ZERO_IDX);
            match_rt_s[k] = valid_r[k] & (dst_r[k] == i_rt_query) & (i_rt_query != ZERO_IDX);
        end
    end

    // Flatten stage array onto the packed output bus.
    always_comb begin
        o_dst_stage = {(STAGES*BITS_REGS){1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            o_dst_stage[k*BITS_REGS +: BITS_REGS] = dst_r[k];
        end
    end

    assign o_valid_stage = valid_r;
    assign o_wb_reg      = dst_r[STAGES-1];
    assign o_wb_write    = valid_r[STAGES-1];
    assign o_match_rs    = match_rs_s;
    assign o_match_rt    = match_rt_s;

`ifdef REG_DST_FWD_PRIORITY_EN
    // Youngest (lowest-numbered) matching stage wins; encoded as stage index + 1, 0 when none.
    function automatic logic [FW-1:0] first_match(input logic [STAGES-1:0] m);
        logic [FW-1:0] r;
        r = {FW{1'b0}};
        for (int k = STAGES - 1; k >= 0; k--) begin
            r = m[k] ? FW'(k + 1) : r;
        end
        return r;
    endfunction

    assign o_fwd_rs = first_match(match_rs_s);
    assign o_fwd_rt = first_match(match_rt_s);
`endif

endmodule
